accum_frame_mc: RTL and testbench
=================================

Name: accum_frame_mc

Overview:
- Multi-channel, parametrised successor to the single-channel dump-and-restart accumulator.
- Keeps one signed running sum per channel.
- Closes a channel's frame on an explicit in_last flag, or automatically after FRAME_LEN samples.
- Pushes each {channel, sum, sample count, overflow} result into a small output FIFO with valid/ready backpressure. Sits between a sample source and a downstream consumer of frame totals.

Parameters:
- IN_W, 32: input sample width, signed two's complement.
- ACC_W, 40: accumulator width, signed. Must satisfy ACC_W >= IN_W.
- NCH, 4: number of channels, >= 2.
- CH_W, $clog2(NCH): channel index width.
- CNT_W, 16: per-channel sample counter width.
- FRAME_LEN, 0: auto-close length in samples. 0 = close on in_last only. Must be < 2^CNT_W.
- SAT, 0: 0 = wrap on overflow; 1 = saturate to signed ACC_W max/min.
- OUT_DEPTH, 4: output FIFO depth, power of two, >= 2.

Ports:
- clk       in   1      rising-edge clock
- rst       in   1      synchronous active-high reset
- in_valid  in   1      sample present
- in_ready  out  1      block can accept a sample
- in_ch     in   CH_W   target channel; values >= NCH are ignored
- in_data   in   IN_W   signed sample
- in_last   in   1      sample closes the channel's frame
- out_valid out  1      FIFO head valid
- out_ready in   1      consumer accepts head
- out_ch    out  CH_W   channel of result
- out_sum   out  ACC_W  frame total, signed
- out_cnt   out  CNT_W  samples in frame, including the closing one
- out_ovf   out  1      overflow occurred during frame (sticky per frame)

Behaviour:
- Reset (rst=1 at posedge):
  - All acc[ch]=0, cnt[ch]=0, ovf[ch]=0.
  - FIFO emptied, so out_valid=0; out_ch/out_sum/out_cnt/out_ovf=0.
  - in_ready=0 while rst is high, 1 from the first cycle after release.
  - Reset mid-frame discards partial sums and queued results.
- Accept: a sample is taken when in_valid && in_ready && in_ch<NCH. If in_ch>=NCH, the sample is consumed with no effect.
- Arithmetic: nxt = acc[ch] + sext(in_data) at ACC_W+1 bits. Overflow is detected when the top two bits of nxt differ.
  - SAT=0: acc takes the low ACC_W bits (wrap).
  - SAT=1: acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Either mode: ovf[ch] is set on overflow.
- Close condition: the accepted sample has in_last=1, or (FRAME_LEN!=0 && cnt[ch]+1==FRAME_LEN).
- On close:
  - Push {ch, nxt result, cnt[ch]+1, ovf[ch]|overflow_now} into the FIFO.
  - Set acc[ch]=0, cnt[ch]=0, ovf[ch]=0 in the same cycle.
  - The next sample on that channel starts a new frame from 0, with no lost cycle.
- Not closing: acc[ch] and cnt[ch] update, and cnt[ch]+1 is written.
- Counter: if cnt reaches 2^CNT_W-1 without a close, it holds at max (no wrap). Sum accumulation continues.
- Latency: a result is visible on out_* at the posedge after the closing sample is accepted (1 cycle). out_* is driven from the FIFO head register.
- Output handshake:
  - The head pops when out_valid && out_ready.
  - out_* must stay stable while out_valid && !out_ready.
- Backpressure: in_ready = !rst && (fifo_count < OUT_DEPTH), computed from the registered count.
  - When the FIFO is full, in_ready=0 even if a pop occurs that cycle. All samples stall, including non-closing ones.
  - Simultaneous push and pop with count < OUT_DEPTH leaves the count unchanged and preserves order.
- Other channels are unaffected by an accepted sample; only acc/cnt/ovf of in_ch change.
- FIFO ordering is strictly close order across channels.

Test Plan:
- Reset, then ch0 samples 5, 7, -2 with last on -2 → one cycle later out_valid=1, out_ch=0, out_sum=10, out_cnt=3, out_ovf=0; acc[0] restarts at 0.
- Interleave ch1: 100, 200 and ch2: -50 (last) → ch2 result sum=-50, cnt=1 first; then ch1 last with 300 → sum=600, cnt=3. FIFO order ch2, ch1.
- IN_W=8, ACC_W=8, SAT=1: ch0 adds 100, 100 (last) → out_sum=127, out_ovf=1. With SAT=0 the same stimulus gives out_sum=-56, out_ovf=1.
- FRAME_LEN=4, ch3 receives 1, 2, 3, 4, 5 with no in_last → result sum=10, cnt=4 after the 4th sample; the 5th sample starts a new frame with acc=5, cnt=1.
- out_ready=0 while OUT_DEPTH+1 frames close → in_ready drops after 4 pushes and the held sample stalls. Raise out_ready → results drain in order with stable data under stall; the stalled sample is accepted afterwards.
- Assert rst mid-frame (ch0 acc=42) with 2 results queued → out_valid=0 next cycle; a subsequent ch0 last with 1 gives sum=1, cnt=1.

Source files
------------

// File: rtl/accum_frame_mc.sv
// accum_frame_mc: multi-channel framed signed accumulator with result FIFO
module accum_frame_mc #(
    parameter int IN_W      = 32,
    parameter int ACC_W     = 40,
    parameter int NCH       = 4,
    parameter int CH_W      = $clog2(NCH),
    parameter int CNT_W     = 16,
    parameter int FRAME_LEN = 0,
    parameter int SAT       = 0,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);
    localparam int AW = $clog2(OUT_DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic [ACC_W-1:0] acc_q [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [NCH-1:0]   ovf_q;
    res_t             mem [OUT_DEPTH];
    res_t             head;
    logic [AW-1:0]    rp, wp;
    logic [AW:0]      count;
    logic [ACC_W-1:0] cur_acc, res;
    logic [CNT_W-1:0] cur_cnt, cnt1;
    logic [ACC_W:0]   nxt;
    logic             cur_ovf, ch_ok, ov, close, take, push, pop;

    assign in_ready  = !rst && (count != (AW+1)'(OUT_DEPTH));
    assign out_valid = count != '0;
    assign head      = mem[rp];
    assign out_ch    = out_valid ? head.ch  : '0;
    assign out_sum   = out_valid ? head.sum : '0;
    assign out_cnt   = out_valid ? head.cnt : '0;
    assign out_ovf   = out_valid && head.ovf;

    // Fetch the addressed channel's state; codes with no channel leave ch_ok low
    always_comb begin
        cur_acc = '0;
        cur_cnt = '0;
        cur_ovf = 1'b0;
        ch_ok   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CH_W'(i)) begin
                cur_acc = acc_q[i];
                cur_cnt = cnt_q[i];
                cur_ovf = ovf_q[i];
                ch_ok   = 1'b1;
            end
        end
    end

    // One extra bit of headroom exposes overflow; counter holds at its maximum
    always_comb begin
        nxt   = {cur_acc[ACC_W-1], cur_acc} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        ov    = nxt[ACC_W] ^ nxt[ACC_W-1];
        res   = (ov && SAT != 0) ? (nxt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                                 : nxt[ACC_W-1:0];
        cnt1  = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
        close = in_last || (FRAME_LEN != 0 && cnt1 == CNT_W'(FRAME_LEN));
        take  = in_valid && in_ready && ch_ok;
        push  = take && close;
        pop   = out_valid && out_ready;
    end

    // Per-channel state: restart from zero on close, otherwise accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (take) begin
            for (int i = 0; i < NCH; i++) begin
                if (in_ch == CH_W'(i)) begin
                    acc_q[i] <= close ? '0 : res;
                    cnt_q[i] <= close ? '0 : cnt1;
                    ovf_q[i] <= !close && (cur_ovf || ov);
                end
            end
        end
    end

    // Result FIFO in close order; head register feeds the outputs directly
    always_ff @(posedge clk) begin
        if (rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= {in_ch, res, cnt1, cur_ovf || ov};
                wp      <= wp + AW'(1);
            end
            if (pop)
                rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_accum_frame_mc.sv
// tb_accum_frame_mc: directed table and corner sequences for accum_frame_mc
module tb_accum_frame_mc;
    typedef struct {
        logic [2:0]         ch;
        logic [31:0]        d;
        logic               last;
        logic               ev;
        logic [2:0]         ech;
        logic signed [39:0] es;
        logic [15:0]        ec;
        logic               eo;
    } vec_t;

    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
    logic [2:0]  ch = 0;
    logic [31:0] d = 0;
    int checks = 0, errors = 0;

    logic u0_in_ready, u0_valid, u0_ovf;
    logic [2:0] u0_ch;
    logic signed [39:0] u0_sum;
    logic [15:0] u0_cnt;

    logic us_in_ready, us_valid, us_ovf;
    logic [1:0] us_ch, us_cnt;
    logic signed [7:0] us_sum;

    logic uw_in_ready, uw_valid, uw_ovf;
    logic [1:0] uw_ch;
    logic signed [7:0] uw_sum;
    logic [15:0] uw_cnt;

    logic uf_in_ready, uf_valid, uf_ovf;
    logic [1:0] uf_ch;
    logic signed [39:0] uf_sum;
    logic [2:0] uf_cnt;

    always #5 clk = ~clk;

    accum_frame_mc #(.NCH(5)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u0_in_ready), .in_ch(ch),
        .in_data(d), .in_last(in_last), .out_valid(u0_valid), .out_ready(out_ready),
        .out_ch(u0_ch), .out_sum(u0_sum), .out_cnt(u0_cnt), .out_ovf(u0_ovf));

    accum_frame_mc #(.IN_W(8), .ACC_W(8), .SAT(1), .CNT_W(2)) us (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(us_in_ready), .in_ch(ch[1:0]),
        .in_data(d[7:0]), .in_last(in_last), .out_valid(us_valid), .out_ready(out_ready),
        .out_ch(us_ch), .out_sum(us_sum), .out_cnt(us_cnt), .out_ovf(us_ovf));

    accum_frame_mc #(.IN_W(8), .ACC_W(8), .SAT(0)) uw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uw_in_ready), .in_ch(ch[1:0]),
        .in_data(d[7:0]), .in_last(in_last), .out_valid(uw_valid), .out_ready(out_ready),
        .out_ch(uw_ch), .out_sum(uw_sum), .out_cnt(uw_cnt), .out_ovf(uw_ovf));

    accum_frame_mc #(.FRAME_LEN(4), .CNT_W(3)) uf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uf_in_ready), .in_ch(ch[1:0]),
        .in_data(d), .in_last(in_last), .out_valid(uf_valid), .out_ready(out_ready),
        .out_ch(uf_ch), .out_sum(uf_sum), .out_cnt(uf_cnt), .out_ovf(uf_ovf));

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input int c, input int v, input int l);
        in_valid = 1;
        ch = 3'(c);
        d = v;
        in_last = l != 0;
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic reset_dut();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    function automatic vec_t mk(input int c, input int v, input int l, input int ev, input int ec, input int es, input int en, input int eo);
        vec_t r;
        r.ch = 3'(c);
        r.d = v;
        r.last = l != 0;
        r.ev = ev != 0;
        r.ech = 3'(ec);
        r.es = 40'(es);
        r.ec = 16'(en);
        r.eo = eo != 0;
        return r;
    endfunction

    vec_t tbl[12];
    logic signed [39:0] bp_sum[5];
    logic [2:0] bp_ch[5];
    logic acc_now, accepted;

    initial begin
        tbl[0]  = mk(0, 5, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 7, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, -2, 1, 1, 0, 10, 3, 0);
        tbl[3]  = mk(1, 100, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(2, -50, 1, 1, 2, -50, 1, 0);
        tbl[5]  = mk(1, 200, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 300, 1, 1, 1, 600, 3, 0);
        tbl[7]  = mk(0, 4, 1, 1, 0, 4, 1, 0);
        tbl[8]  = mk(6, 999, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 1, 1, 1, 1, 1, 0);
        tbl[10] = mk(3, 32'h8000_0000, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(3, 32'h8000_0000, 1, 1, 3, 0, 2, 0);
        tbl[11].es = -40'sd4294967296;

        @(posedge clk);
        #1;
        chk("rst_in_ready_u0", 64'(u0_in_ready), 0);
        chk("rst_in_ready_us", 64'(us_in_ready), 0);
        chk("rst_in_ready_uw", 64'(uw_in_ready), 0);
        chk("rst_in_ready_uf", 64'(uf_in_ready), 0);
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(u0_valid), 0);
        chk("rst_ch", 64'(u0_ch), 0);
        chk("rst_sum", 64'(u0_sum), 0);
        chk("rst_cnt", 64'(u0_cnt), 0);
        chk("rst_ovf", 64'(u0_ovf), 0);
        chk("rst_valid_all", 64'({us_valid, uw_valid, uf_valid}), 0);
        rst = 0;
        #1;
        chk("rel_in_ready_u0", 64'(u0_in_ready), 1);
        chk("rel_in_ready_uf", 64'(uf_in_ready), 1);

        foreach (tbl[i]) begin
            send(int'(tbl[i].ch), int'(tbl[i].d), int'(tbl[i].last));
            chk($sformatf("vec%0d_valid", i), 64'(u0_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_ch", i), 64'(u0_ch), 64'(tbl[i].ech));
                chk($sformatf("vec%0d_sum", i), 64'(u0_sum), 64'(tbl[i].es));
                chk($sformatf("vec%0d_cnt", i), 64'(u0_cnt), 64'(tbl[i].ec));
                chk($sformatf("vec%0d_ovf", i), 64'(u0_ovf), 64'(tbl[i].eo));
            end
        end

        reset_dut();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            send(i, 10 * (i + 1), 1);
            bp_sum[i] = 40'(10 * (i + 1));
            bp_ch[i] = 3'(i);
        end
        bp_sum[4] = 40'(50);
        bp_ch[4] = 3'(0);
        chk("bp_full_ready", 64'(u0_in_ready), 0);
        chk("bp_full_head", 64'(u0_sum), 10);
        in_valid = 1;
        ch = 0;
        d = 50;
        in_last = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stall_ready", 64'(u0_in_ready), 0);
        chk("bp_stall_valid", 64'(u0_valid), 1);
        chk("bp_stall_sum", 64'(u0_sum), 10);
        chk("bp_stall_ch", 64'(u0_ch), 0);
        out_ready = 1;
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_drain%0d_valid", k), 64'(u0_valid), 1);
            chk($sformatf("bp_drain%0d_sum", k), 64'(u0_sum), 64'(bp_sum[k]));
            chk($sformatf("bp_drain%0d_ch", k), 64'(u0_ch), 64'(bp_ch[k]));
            acc_now = in_valid && u0_in_ready;
            @(posedge clk);
            #1;
            if (acc_now) begin
                accepted = 1;
                in_valid = 0;
                in_last = 0;
            end
        end
        chk("bp_empty", 64'(u0_valid), 0);
        chk("bp_accepted", 64'(accepted), 1);

        reset_dut();
        out_ready = 0;
        send(1, 5, 1);
        send(2, 6, 1);
        send(0, 42, 0);
        chk("rm_pre_valid", 64'(u0_valid), 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("rm_valid", 64'(u0_valid), 0);
        chk("rm_in_ready_rst", 64'(u0_in_ready), 0);
        rst = 0;
        #1;
        chk("rm_in_ready", 64'(u0_in_ready), 1);
        out_ready = 1;
        send(0, 1, 1);
        chk("rm_valid_after", 64'(u0_valid), 1);
        chk("rm_sum", 64'(u0_sum), 1);
        chk("rm_cnt", 64'(u0_cnt), 1);

        reset_dut();
        send(0, 100, 0);
        send(0, 100, 1);
        chk("sat_pos_valid", 64'(us_valid), 1);
        chk("sat_pos_sum", 64'(us_sum), 127);
        chk("sat_pos_ovf", 64'(us_ovf), 1);
        chk("sat_pos_cnt", 64'(us_cnt), 2);
        chk("wrap_pos_sum", 64'(uw_sum), -56);
        chk("wrap_pos_ovf", 64'(uw_ovf), 1);
        send(0, -100, 0);
        send(0, -100, 1);
        chk("sat_neg_sum", 64'(us_sum), -128);
        chk("sat_neg_ovf", 64'(us_ovf), 1);
        chk("wrap_neg_sum", 64'(uw_sum), 56);
        chk("wrap_neg_ovf", 64'(uw_ovf), 1);
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        send(1, 1, 1);
        chk("cnt_hold_cnt", 64'(us_cnt), 3);
        chk("cnt_hold_sum", 64'(us_sum), 5);
        chk("cnt_hold_ch", 64'(us_ch), 1);
        chk("cnt_free_cnt", 64'(uw_cnt), 5);
        chk("cnt_free_ch", 64'(uw_ch), 1);
        send(0, 100, 0);
        send(0, 100, 0);
        send(0, 10, 1);
        chk("sticky_wrap_sum", 64'(uw_sum), -46);
        chk("sticky_wrap_ovf", 64'(uw_ovf), 1);
        chk("sticky_sat_sum", 64'(us_sum), 127);
        chk("sticky_sat_ovf", 64'(us_ovf), 1);
        send(0, 3, 1);
        chk("ovf_clear_sum", 64'(uw_sum), 3);
        chk("ovf_clear_ovf", 64'(uw_ovf), 0);
        chk("ovf_clear_valid", 64'(uw_valid), 1);

        reset_dut();
        send(3, 1, 0);
        send(3, 2, 0);
        send(3, 3, 0);
        chk("fl_pre_valid", 64'(uf_valid), 0);
        send(3, 4, 0);
        chk("fl_valid", 64'(uf_valid), 1);
        chk("fl_ch", 64'(uf_ch), 3);
        chk("fl_sum", 64'(uf_sum), 10);
        chk("fl_cnt", 64'(uf_cnt), 4);
        chk("fl_ovf", 64'(uf_ovf), 0);
        send(3, 5, 0);
        chk("fl_open_valid", 64'(uf_valid), 0);
        send(3, 6, 1);
        chk("fl_next_sum", 64'(uf_sum), 11);
        chk("fl_next_cnt", 64'(uf_cnt), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
